inst_mem_loader: RTL and testbench

//  Boot-time writer for the instruction memory. Receives a byte stream
//  (valid/ready), packs bytes into 32-bit instruction words and writes them

---
 rtl/inst_mem_loader_pkg.sv | 16 +
 rtl/inst_mem_loader_word_packer.sv | 41 ++++
 rtl/inst_mem_loader.sv | 118 +++++++++++
 tb/tb_inst_mem_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
// State encodings and stream framing constants.
package inst_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/inst_mem_loader_word_packer.sv
// Packs a big-endian byte stream into 32-bit words.
// word/word_valid appear the cycle after the 4th byte is accepted.
module word_packer
  import inst_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_last,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  assign word_last = byte_valid && (cnt_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= word_last;
      if (clr) begin
        cnt_q <= '0;
      end else if (byte_valid) begin
        shift_q <= {shift_q[15:0], byte_data};
        cnt_q   <= cnt_q + 2'd1;
        if (word_last) begin
          word <= {shift_q, byte_data};
        end
      end
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Boot-time loader: length-prefixed byte stream -> consecutive word writes
// into the instruction store, holding the CPU until the image is complete.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold,
  output state_t            state_dbg
);

  // Stream handshake: a byte transfers on a rising clk edge exactly when
  // in_valid && in_ready; in_ready depends only on the current state, never
  // on in_valid, and the producer must hold in_data stable while in_valid=1.

  state_t            state_q, state_d;
  logic [7:0]        len_hi_q;
  logic [15:0]       len_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              accept;
  logic [15:0]       len_in;
  logic              word_last;
  logic              last_word;

  assign accept    = in_valid && in_ready;
  assign len_in    = {len_hi_q, in_data};
  assign last_word = ({{(16-ADDR_W){1'b0}}, word_idx_q} + 16'd1) == len_q;
  assign state_dbg = state_q;
  assign wr_addr   = wr_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_d = ST_LEN_HI;
      ST_LEN_HI: if (accept) state_d = ST_LEN_LO;
      ST_LEN_LO: begin
        if (accept) begin
          if (len_in == 16'd0)             state_d = ST_DONE;
          else if (len_in > 16'(DEPTH))    state_d = ST_ERR;
          else                             state_d = ST_DATA;
        end
      end
      ST_DATA: if (word_last && last_word) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    cpu_hold = 1'b0;
    case (state_q)
      ST_LEN_HI, ST_LEN_LO, ST_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
      end
      ST_DONE: done = 1'b1;
      ST_ERR: begin
        err      = 1'b1;
        cpu_hold = 1'b1;
      end
      default: ;
    endcase
  end

  // Word address is latched with the 4th byte so it lines up with wr_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_hi_q   <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      wr_addr_q  <= '0;
    end else begin
      if (accept && state_q == ST_LEN_HI) len_hi_q <= in_data;
      if (accept && state_q == ST_LEN_LO) len_q    <= len_in;
      if (state_q == ST_LEN_LO) begin
        word_idx_q <= '0;
      end else if (word_last) begin
        wr_addr_q  <= word_idx_q;
        word_idx_q <= word_idx_q + 1'b1;
      end
    end
  end

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (state_q != ST_DATA),
    .byte_valid (accept && state_q == ST_DATA),
    .byte_data  (in_data),
    .word_last  (word_last),
    .word_valid (wr_en),
    .word       (wr_data)
  );

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader with a write scoreboard.
module tb_inst_mem_loader;
  import inst_mem_loader_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready, wr_en, busy, done, err, cpu_hold;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  state_t            state_dbg;

  int vectors = 0;
  int miscompares = 0;
  int wr_count = 0;
  int base;
  logic [ADDR_W+31:0] exp_q[$];
  logic [31:0] img [4] = '{32'h8C02000E, 32'h11290002, 32'hA5A50F0F, 32'h00000013};

  inst_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) check("wr_without_expect", 34'(exp_q.size()), 34'd1);
      else check("wr_addr_data", {wr_addr, wr_data}, exp_q.pop_front());
    end
  end

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap, input bit with_start);
    int n = 0;
    repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    start    = with_start;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("accept_timeout", 34'(n), 34'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] n);
    logic [15:0] v = n;
    send_byte(v[15:8], 0, 1'b0);
    send_byte(v[7:0], 0, 1'b0);
  endtask

  task automatic send_word(input int addr, input logic [31:0] w, input int max_gap,
                           input bit last_start);
    exp_q.push_back({ADDR_W'(addr), w});
    for (int i = 0; i < 4; i++)
      send_byte(w[31-8*i -: 8], max_gap, last_start && (i == 3));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 34'(in_ready), 34'd0);
    check({tag, "_wr_en"},    34'(wr_en),    34'd0);
    check({tag, "_busy"},     34'(busy),     34'd0);
    check({tag, "_done"},     34'(done),     34'd0);
    check({tag, "_err"},      34'(err),      34'd0);
    check({tag, "_cpu_hold"}, 34'(cpu_hold), 34'd0);
    check({tag, "_wr_addr"},  34'(wr_addr),  34'd0);
    check({tag, "_wr_data"},  34'(wr_data),  34'd0);
    check({tag, "_state"},    34'(state_dbg), 34'(ST_IDLE));
  endtask

  initial begin
    // Reset values
    settle(3);
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: two-word image
    base = wr_count;
    pulse_start();
    check("c1_busy", 34'(busy), 34'd1);
    check("c1_hold", 34'(cpu_hold), 34'd1);
    check("c1_ready", 34'(in_ready), 34'd1);
    send_len(16'd2);
    send_word(0, 32'h8C02000E, 0, 1'b0);
    send_word(1, 32'h11290002, 0, 1'b0);
    settle(1);
    check("c1_done", 34'(done), 34'd1);
    check("c1_hold_off", 34'(cpu_hold), 34'd0);
    check("c1_ready_off", 34'(in_ready), 34'd0);
    check("c1_writes", 34'(wr_count - base), 34'd2);

    // 2: zero-length image
    base = wr_count;
    pulse_start();
    check("c2_done_cleared", 34'(done), 34'd0);
    send_len(16'd0);
    check("c2_done", 34'(done), 34'd1);
    check("c2_busy", 34'(busy), 34'd0);
    settle(3);
    check("c2_writes", 34'(wr_count - base), 34'd0);

    // 3: oversize image rejected, then a valid reload
    base = wr_count;
    pulse_start();
    send_len(16'd5);
    settle(1);
    check("c3_err", 34'(err), 34'd1);
    check("c3_ready", 34'(in_ready), 34'd0);
    check("c3_hold", 34'(cpu_hold), 34'd1);
    check("c3_busy", 34'(busy), 34'd0);
    settle(3);
    check("c3_writes", 34'(wr_count - base), 34'd0);
    pulse_start();
    check("c3_err_cleared", 34'(err), 34'd0);
    send_len(16'd1);
    send_word(0, 32'hDEADBEEF, 0, 1'b0);
    settle(1);
    check("c3_done", 34'(done), 34'd1);
    check("c3_err_off", 34'(err), 34'd0);

    // 4: full-depth image with random in_valid gaps
    base = wr_count;
    pulse_start();
    send_len(16'd4);
    for (int i = 0; i < 4; i++) send_word(i, img[i], 3, 1'b0);
    settle(2);
    check("c4_writes", 34'(wr_count - base), 34'd4);
    check("c4_done", 34'(done), 34'd1);
    check("c4_queue", 34'(exp_q.size()), 34'd0);

    // 5: reset in the middle of word 1
    pulse_start();
    send_len(16'd2);
    send_word(0, 32'h8C02000E, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h29, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    settle(1);
    check_idle_outputs("c5_rst");
    @(negedge clk);
    rst = 1'b0;
    base = wr_count;
    settle(5);
    check("c5_no_wr", 34'(wr_count - base), 34'd0);
    pulse_start();
    send_len(16'd1);
    send_word(0, 32'h00500093, 0, 1'b0);
    settle(1);
    check("c5_done", 34'(done), 34'd1);
    check("c5_writes", 34'(wr_count - base), 34'd1);

    // 6: start ignored in DATA and alongside the final byte; honoured in DONE
    base = wr_count;
    pulse_start();
    send_len(16'd2);
    exp_q.push_back({ADDR_W'(0), 32'h01020304});
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    pulse_start();
    check("c6_state_data", 34'(state_dbg), 34'(ST_DATA));
    check("c6_busy", 34'(busy), 34'd1);
    send_byte(8'h03, 0, 1'b0);
    send_byte(8'h04, 0, 1'b0);
    send_word(1, 32'hCAFEF00D, 0, 1'b1);
    settle(1);
    check("c6_done", 34'(done), 34'd1);
    check("c6_busy_off", 34'(busy), 34'd0);
    check("c6_writes", 34'(wr_count - base), 34'd2);
    pulse_start();
    check("c6_restart_done", 34'(done), 34'd0);
    check("c6_restart_busy", 34'(busy), 34'd1);
    send_len(16'd0);
    check("c6_done2", 34'(done), 34'd1);

    settle(2);
    check("final_queue", 34'(exp_q.size()), 34'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
